// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/redirect control for the 5-stage RV32I pipeline.
// Handles load-use hazards, EX-resolved mispredicts, data-memory freeze,
// a memory-wait watchdog and two performance counters.
module hazard_ctrl #(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs1D,
   input  logic [4:0]       rs2D,
   input  logic             useRs1D,
   input  logic             useRs2D,
   input  logic             MemReadE,
   input  logic [4:0]       rdE,
   input  logic             BranchE,
   input  logic             takenE,
   input  logic [31:0]      targetE,
   input  logic [31:0]      pcE,
   input  logic             pred_takenE,
   input  logic [31:0]      pred_targetE,
   input  logic             mem_wait,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             flushD,
   output logic             flushE,
   output logic             redirect,
   output logic [31:0]      redirect_pc,
   output logic             timeout_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] mispredicts
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      RUN,
      FREEZE,
      TIMEOUT
   } state_t;

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   waitCnt_q, waitCnt_d;
   logic                timeoutErr_q, timeoutErr_d;
   logic [CNT_W-1:0]    stallCycles_q;
   logic [CNT_W-1:0]    mispredicts_q;

   logic                loadUse;
   logic                mispred;
   logic [31:0]         fixPc;
   logic                evalHazards;
   logic                anyStall;

   // Hazard detection terms and the corrected PC for a mispredicted branch
   always_comb begin
      loadUse = MemReadE && (rdE != 5'd0) &&
                ((useRs1D && (rs1D == rdE)) || (useRs2D && (rs2D == rdE)));
      mispred = BranchE && ((takenE != pred_takenE) ||
                            (takenE && (targetE != pred_targetE)));
      fixPc   = takenE ? targetE : (pcE + 32'd4);
   end

   // Next-state logic and pipeline controls; memory freeze beats mispredict beats load-use
   always_comb begin
      stallF       = 1'b0;
      stallD       = 1'b0;
      stallE       = 1'b0;
      stallM       = 1'b0;
      flushD       = 1'b0;
      flushE       = 1'b0;
      redirect     = 1'b0;
      redirect_pc  = 32'd0;
      evalHazards  = 1'b0;
      state_d      = state_q;
      waitCnt_d    = waitCnt_q;
      timeoutErr_d = timeoutErr_q;

      if (!reset) begin
         case (state_q)
            RUN: begin
               if (mem_wait) begin
                  stallF    = 1'b1;
                  stallD    = 1'b1;
                  stallE    = 1'b1;
                  stallM    = 1'b1;
                  state_d   = FREEZE;
                  waitCnt_d = WAIT_W'(1);
               end else begin
                  evalHazards = 1'b1;
               end
            end
            FREEZE: begin
               if (mem_wait) begin
                  stallF    = 1'b1;
                  stallD    = 1'b1;
                  stallE    = 1'b1;
                  stallM    = 1'b1;
                  waitCnt_d = waitCnt_q + WAIT_W'(1);
                  if (waitCnt_q == WAIT_W'(MAX_WAIT - 1)) begin
                     state_d      = TIMEOUT;
                     timeoutErr_d = 1'b1;
                  end
               end else begin
                  state_d     = RUN;
                  waitCnt_d   = '0;
                  evalHazards = 1'b1;
               end
            end
            TIMEOUT: begin
               stallF       = 1'b1;
               stallD       = 1'b1;
               stallE       = 1'b1;
               stallM       = 1'b1;
               timeoutErr_d = 1'b1;
            end
            default: begin
               state_d = RUN;
            end
         endcase

         if (evalHazards) begin
            if (mispred) begin
               redirect    = 1'b1;
               redirect_pc = fixPc;
               flushD      = 1'b1;
               flushE      = 1'b1;
            end else if (loadUse) begin
               stallF = 1'b1;
               stallD = 1'b1;
               flushE = 1'b1;
            end
         end
      end
   end

   assign anyStall = stallF | stallD | stallE | stallM;

   // State, watchdog and performance counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= RUN;
         waitCnt_q     <= '0;
         timeoutErr_q  <= 1'b0;
         stallCycles_q <= '0;
         mispredicts_q <= '0;
      end else begin
         state_q      <= state_d;
         waitCnt_q    <= waitCnt_d;
         timeoutErr_q <= timeoutErr_d;
         if (anyStall) begin
            stallCycles_q <= stallCycles_q + CNT_W'(1);
         end
         if (redirect) begin
            mispredicts_q <= mispredicts_q + CNT_W'(1);
         end
      end
   end

   assign timeout_err  = timeoutErr_q;
   assign stall_cycles = stallCycles_q;
   assign mispredicts  = mispredicts_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  rs1D, rs2D, rdE;
   logic        useRs1D, useRs2D, MemReadE;
   logic        BranchE, takenE, pred_takenE, mem_wait;
   logic [31:0] targetE, pcE, pred_targetE;
   logic        stallF, stallD, stallE, stallM, flushD, flushE, redirect;
   logic [31:0] redirect_pc;
   logic        timeout_err;
   logic [31:0] stall_cycles, mispredicts;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] LU   = 7'b1100010;
   localparam logic [6:0] MP   = 7'b0000111;
   localparam logic [6:0] FZ   = 7'b1111000;

   logic [6:0] ctrl;
   assign ctrl = {stallF, stallD, stallE, stallM, flushD, flushE, redirect};

   hazard_ctrl #(.MAX_WAIT(16), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
      .MemReadE(MemReadE), .rdE(rdE),
      .BranchE(BranchE), .takenE(takenE), .targetE(targetE), .pcE(pcE),
      .pred_takenE(pred_takenE), .pred_targetE(pred_targetE),
      .mem_wait(mem_wait),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushD(flushD), .flushE(flushE),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .timeout_err(timeout_err),
      .stall_cycles(stall_cycles), .mispredicts(mispredicts)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic mr, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                                input logic u1, input logic u2, input logic br, input logic tk,
                                input logic [31:0] tgt, input logic [31:0] pc, input logic ptk,
                                input logic [31:0] ptgt, input logic mw);
      MemReadE = mr; rdE = rd; rs1D = r1; rs2D = r2; useRs1D = u1; useRs2D = u2;
      BranchE = br; takenE = tk; targetE = tgt; pcE = pc; pred_takenE = ptk;
      pred_targetE = ptgt; mem_wait = mw;
   endtask

   // Combinational controls checked mid-cycle, counters checked just after the edge
   task automatic checkCycle(input string tag, input logic [6:0] expCtrl, input logic [31:0] expPc,
                             input logic [31:0] expStalls, input logic [31:0] expMisp);
      @(negedge clk);
      checkOutput({tag, "_ctrl"}, 64'(ctrl), 64'(expCtrl));
      if (expCtrl[0]) checkOutput({tag, "_rpc"}, 64'(redirect_pc), 64'(expPc));
      @(posedge clk);
      #1;
      checkOutput({tag, "_stalls"}, 64'(stall_cycles), 64'(expStalls));
      checkOutput({tag, "_misp"}, 64'(mispredicts), 64'(expMisp));
   endtask

   initial begin
      reset = 1'b1;
      // Reset with a mispredict presented: controls must stay low
      applyStimulus(1, 5'd5, 5'd0, 5'd5, 0, 1, 1, 1, 32'h100, 32'h0, 0, 32'h0, 0);
      checkCycle("reset", NONE, 32'h0, 0, 0);
      checkOutput("reset_timeout", 64'(timeout_err), 64'd0);
      reset = 1'b0;

      applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
      checkCycle("idle", NONE, 32'h0, 0, 0);

      // Load-use hazards
      applyStimulus(1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
      checkCycle("lu_rs2", LU, 32'h0, 1, 0);
      applyStimulus(1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
      checkCycle("lu_rd0", NONE, 32'h0, 1, 0);
      applyStimulus(1, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
      checkCycle("lu_unused", NONE, 32'h0, 1, 0);
      applyStimulus(0, 5'd7, 5'd7, 5'd0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
      checkCycle("lu_noload", NONE, 32'h0, 1, 0);
      applyStimulus(1, 5'd7, 5'd7, 5'd0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
      checkCycle("lu_rs1", LU, 32'h0, 2, 0);

      // Mispredicts
      applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 32'h100, 32'h40, 0, 32'h0, 0);
      checkCycle("mp_nt_t", MP, 32'h100, 2, 1);
      applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 32'h200, 32'hFFFF_FFFC, 1, 32'h200, 0);
      checkCycle("mp_wrap", MP, 32'h0000_0000, 2, 2);
      applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 32'h300, 32'h80, 1, 32'h300, 0);
      checkCycle("bp_ok", NONE, 32'h0, 2, 2);
      applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 32'h340, 32'h80, 1, 32'h300, 0);
      checkCycle("mp_tgt", MP, 32'h340, 2, 3);
      applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 32'h340, 32'h80, 0, 32'h300, 0);
      checkCycle("nobranch", NONE, 32'h0, 2, 3);

      // Mispredict and load-use together: redirect wins
      applyStimulus(1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 1, 32'h100, 32'h40, 0, 32'h0, 0);
      checkCycle("mp_lu", MP, 32'h100, 2, 4);

      // Freeze for 3 cycles with the same hazards present
      mem_wait = 1'b1;
      checkCycle("frz1", FZ, 32'h0, 3, 4);
      checkCycle("frz2", FZ, 32'h0, 4, 4);
      checkCycle("frz3", FZ, 32'h0, 5, 4);
      applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
      checkCycle("frz_exit", NONE, 32'h0, 5, 4);

      // Freeze exit cycle evaluates hazards in the same cycle
      mem_wait = 1'b1;
      checkCycle("frz4", FZ, 32'h0, 6, 4);
      applyStimulus(1, 5'd9, 5'd0, 5'd9, 0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
      checkCycle("frz_exit_lu", LU, 32'h0, 7, 4);
      applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1);
      checkCycle("frz5", FZ, 32'h0, 8, 4);
      applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 32'h0, 32'h20, 1, 32'h44, 0);
      checkCycle("frz_exit_mp", MP, 32'h24, 8, 5);

      // Watchdog: 16 edges of mem_wait reach TIMEOUT
      applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1);
      for (int i = 1; i <= 16; i++) begin
         checkCycle("wdog", FZ, 32'h0, 32'(8 + i), 5);
         checkOutput("wdog_err", 64'(timeout_err), (i == 16) ? 64'd1 : 64'd0);
      end
      applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 32'h100, 32'h0, 0, 32'h0, 0);
      checkCycle("tmo_hold", FZ, 32'h0, 25, 5);
      checkOutput("tmo_sticky", 64'(timeout_err), 64'd1);

      // Reset mid-timeout
      reset = 1'b1;
      checkCycle("tmo_reset", NONE, 32'h0, 0, 0);
      checkOutput("tmo_reset_err", 64'(timeout_err), 64'd0);
      reset = 1'b0;
      applyStimulus(1, 5'd3, 5'd3, 5'd0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
      checkCycle("post_reset_lu", LU, 32'h0, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
